// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-read/single-write-port data memory.
// Port 0 is the CPU load/store unit, port 1 the debug/DMA loader. One access
// is granted per cycle and driven onto the memory; read data returns one cycle
// later and is qualified by a per-port rvalid.
// Arbitration is fixed priority (port 0) with a starvation bound for port 1 by
// default. Define DMEM_ARB_RR_EN to build round-robin arbitration instead.

`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module dmem_arbiter #(
  parameter int unsigned W        = `WORD_WIDTH,
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic         clk,
  input  logic         rst,
  // port 0
  input  logic         m0_req,
  input  logic         m0_we,
  input  logic [W-1:0] m0_addr,
  input  logic [W-1:0] m0_wdata,
  output logic         m0_gnt,
  output logic         m0_rvalid,
  output logic [W-1:0] m0_rdata,
  // port 1
  input  logic         m1_req,
  input  logic         m1_we,
  input  logic [W-1:0] m1_addr,
  input  logic [W-1:0] m1_wdata,
  output logic         m1_gnt,
  output logic         m1_rvalid,
  output logic [W-1:0] m1_rdata,
  // memory
  output logic         mem_read_en,
  output logic [W-1:0] mem_read_addr,
  input  logic [W-1:0] mem_read_data,
  output logic         mem_write_en,
  output logic [W-1:0] mem_write_addr,
  output logic [W-1:0] mem_write_data
);

  logic grant0;
  logic grant1;
  logic rd_grant;

  // Outstanding read: valid bit plus which port issued it
  logic pend_valid_q;
  logic pend_port_q;

`ifdef DMEM_ARB_RR_EN
  // Set when the most recent grant went to port 0; cleared state favours port 0
  logic last_m0_q;
`else
  localparam int unsigned CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WaitMax = CW'(MAX_WAIT);

  logic [CW-1:0] wait_cnt_q;
  logic          starved;

  assign starved = (wait_cnt_q == WaitMax);
`endif

  // Combinational grant selection; nothing is granted while reset is held
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst) begin
`ifdef DMEM_ARB_RR_EN
      if (m0_req && m1_req) begin
        if (last_m0_q) grant1 = 1'b1;
        else           grant0 = 1'b1;
      end else begin
        grant0 = m0_req;
        grant1 = m1_req;
      end
`else
      if (m1_req && starved) begin
        grant1 = 1'b1;
      end else if (m0_req) begin
        grant0 = 1'b1;
      end else begin
        grant1 = m1_req;
      end
`endif
    end
  end

  assign m0_gnt   = grant0;
  assign m1_gnt   = grant1;
  assign rd_grant = (grant0 && !m0_we) || (grant1 && !m1_we);

  // Drive the winner's access onto exactly one memory interface
  always_comb begin
    mem_read_en    = 1'b0;
    mem_read_addr  = '0;
    mem_write_en   = 1'b0;
    mem_write_addr = '0;
    mem_write_data = '0;
    if (grant0) begin
      if (m0_we) begin
        mem_write_en   = 1'b1;
        mem_write_addr = m0_addr;
        mem_write_data = m0_wdata;
      end else begin
        mem_read_en    = 1'b1;
        mem_read_addr  = m0_addr;
      end
    end else if (grant1) begin
      if (m1_we) begin
        mem_write_en   = 1'b1;
        mem_write_addr = m1_addr;
        mem_write_data = m1_wdata;
      end else begin
        mem_read_en    = 1'b1;
        mem_read_addr  = m1_addr;
      end
    end
  end

  // Record each read grant so its data can be steered back next cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_valid_q <= 1'b0;
      pend_port_q  <= 1'b0;
    end else begin
      pend_valid_q <= rd_grant;
      pend_port_q  <= grant1;
    end
  end

  assign m0_rvalid = pend_valid_q && !pend_port_q;
  assign m1_rvalid = pend_valid_q &&  pend_port_q;
  assign m0_rdata  = mem_read_data;
  assign m1_rdata  = mem_read_data;

`ifdef DMEM_ARB_RR_EN
  // Remember who won last so the other port wins the next contention
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_m0_q <= 1'b0;
    end else if (grant0 || grant1) begin
      last_m0_q <= grant0;
    end
  end
`else
  // Count consecutive refusals of port 1; saturates at the forced-grant point
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_q <= '0;
    end else if (m1_req && !grant1) begin
      if (!starved) wait_cnt_q <= wait_cnt_q + CW'(1);
    end else begin
      wait_cnt_q <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: table-driven single-cycle vectors plus
// hand-written sequences for starvation, round-robin and asynchronous reset.
// Includes a small registered-read memory model behind the arbiter.

module tb_dmem_arbiter;

  logic        clk;
  logic        rst;
  logic        m0_req, m0_we, m0_gnt, m0_rvalid;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic        m1_req, m1_we, m1_gnt, m1_rvalid;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic        mem_read_en, mem_write_en;
  logic [31:0] mem_read_addr, mem_read_data, mem_write_addr, mem_write_data;

  int checks;
  int failures;

  dmem_arbiter #(.W(32), .MAX_WAIT(8)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_read_en(mem_read_en), .mem_read_addr(mem_read_addr),
    .mem_read_data(mem_read_data), .mem_write_en(mem_write_en),
    .mem_write_addr(mem_write_addr), .mem_write_data(mem_write_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: write commits at the edge, read data registered one cycle
  logic [31:0] mem [64];
  always @(posedge clk) begin
    if (mem_write_en) mem[mem_write_addr[7:2]] <= mem_write_data;
    if (mem_read_en)  mem_read_data <= mem[mem_read_addr[7:2]];
  end

  typedef struct {
    logic        r0, w0;
    logic [31:0] a0, d0;
    logic        r1, w1;
    logic [31:0] a1, d1;
    logic        g0, g1, v0, v1;
    logic [31:0] rd;
    logic        re, we;
    logic [31:0] ra, wa, wd;
  } vec_t;

  function automatic vec_t mk(logic r0, logic w0, logic [31:0] a0, logic [31:0] d0,
                              logic r1, logic w1, logic [31:0] a1, logic [31:0] d1,
                              logic g0, logic g1, logic v0, logic v1, logic [31:0] rd,
                              logic re, logic we, logic [31:0] ra, logic [31:0] wa,
                              logic [31:0] wd);
    vec_t v;
    v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.g0 = g0; v.g1 = g1; v.v0 = v0; v.v1 = v1; v.rd = rd;
    v.re = re; v.we = we; v.ra = ra; v.wa = wa; v.wd = wd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    m0_req = v.r0; m0_we = v.w0; m0_addr = v.a0; m0_wdata = v.d0;
    m1_req = v.r1; m1_we = v.w1; m1_addr = v.a1; m1_wdata = v.d1;
  endtask

  task automatic idle();
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
  endtask

  localparam int NV = 10;
  vec_t vecs [NV];

  initial begin
    checks   = 0;
    failures = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[0] = 32'hA0A0_0000;
    mem[1] = 32'hB1B1_1111;
    mem[4] = 32'hDEAD_BEEF;
    mem_read_data = '0;

    // Both ports request while reset is held: everything must stay quiet
    rst = 1'b1;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10; m0_wdata = '0;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h24; m1_wdata = 32'h55;
    @(posedge clk); @(negedge clk);
    chk("rst m0_gnt", 32'(m0_gnt), 32'h0);
    chk("rst m1_gnt", 32'(m1_gnt), 32'h0);
    chk("rst read_en", 32'(mem_read_en), 32'h0);
    chk("rst write_en", 32'(mem_write_en), 32'h0);
    chk("rst m0_rvalid", 32'(m0_rvalid), 32'h0);
    chk("rst write_addr", mem_write_addr, 32'h0);
    chk("rst read_addr", mem_read_addr, 32'h0);
    idle();
    rst = 1'b0;

`ifdef DMEM_ARB_RR_EN
    // Continuous contention: grants alternate starting with port 0
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0;
      m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h4;
      #2;
      chk($sformatf("rr%0d m0_gnt", c), 32'(m0_gnt), 32'(c % 2 == 0));
      chk($sformatf("rr%0d m1_gnt", c), 32'(m1_gnt), 32'(c % 2 == 1));
      if (c > 0) begin
        chk($sformatf("rr%0d m0_rvalid", c), 32'(m0_rvalid), 32'(c % 2 == 1));
        chk($sformatf("rr%0d m1_rvalid", c), 32'(m1_rvalid), 32'(c % 2 == 0));
        chk($sformatf("rr%0d rdata", c), m0_rdata,
            (c % 2 == 1) ? 32'hA0A0_0000 : 32'hB1B1_1111);
      end
    end
    @(negedge clk); idle();
    @(negedge clk);
    // Write then read of the same address on consecutive cycles
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h20; m1_wdata = 32'h1234_5678;
    #2 chk("rr wr m1_gnt", 32'(m1_gnt), 32'h1);
    @(negedge clk); idle();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h20;
    #2 chk("rr rd m0_gnt", 32'(m0_gnt), 32'h1);
    @(negedge clk); idle();
    #2;
    chk("rr rd m0_rvalid", 32'(m0_rvalid), 32'h1);
    chk("rr rd m0_rdata", m0_rdata, 32'h1234_5678);
`else
    //            r0    w0    a0     d0           r1    w1    a1     d1
    //            g0    g1    v0    v1    rdata         re    we    raddr  waddr  wdata
    vecs[0] = mk(1'b1, 1'b0, 32'h10, 32'h0,       1'b0, 1'b0, 32'h0,  32'h0,
                 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h10, 32'h0,  32'h0);
    vecs[1] = mk(1'b0, 1'b0, 32'h0,  32'h0,       1'b0, 1'b0, 32'h0,  32'h0,
                 1'b0, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0,  32'h0,  32'h0);
    vecs[2] = mk(1'b1, 1'b1, 32'h30, 32'h1111,    1'b1, 1'b1, 32'h34, 32'h2222,
                 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0,  32'h30, 32'h1111);
    vecs[3] = mk(1'b0, 1'b0, 32'h0,  32'h0,       1'b1, 1'b1, 32'h34, 32'h2222,
                 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0,  32'h34, 32'h2222);
    vecs[4] = mk(1'b0, 1'b0, 32'h0,  32'h0,       1'b1, 1'b1, 32'h20, 32'h12345678,
                 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0,  32'h20, 32'h12345678);
    vecs[5] = mk(1'b1, 1'b0, 32'h20, 32'h0,       1'b0, 1'b0, 32'h0,  32'h0,
                 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h20, 32'h0,  32'h0);
    vecs[6] = mk(1'b0, 1'b0, 32'h0,  32'h0,       1'b1, 1'b0, 32'h30, 32'h0,
                 1'b0, 1'b1, 1'b1, 1'b0, 32'h12345678, 1'b1, 1'b0, 32'h30, 32'h0,  32'h0);
    vecs[7] = mk(1'b1, 1'b0, 32'h34, 32'h0,       1'b1, 1'b0, 32'h4,  32'h0,
                 1'b1, 1'b0, 1'b0, 1'b1, 32'h1111,     1'b1, 1'b0, 32'h34, 32'h0,  32'h0);
    vecs[8] = mk(1'b0, 1'b0, 32'h0,  32'h0,       1'b1, 1'b0, 32'h0,  32'h0,
                 1'b0, 1'b1, 1'b1, 1'b0, 32'h2222,     1'b1, 1'b0, 32'h0,  32'h0,  32'h0);
    vecs[9] = mk(1'b0, 1'b0, 32'h0,  32'h0,       1'b0, 1'b0, 32'h0,  32'h0,
                 1'b0, 1'b0, 1'b0, 1'b1, 32'hA0A00000, 1'b0, 1'b0, 32'h0,  32'h0,  32'h0);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #2;
      chk($sformatf("v%0d m0_gnt", i), 32'(m0_gnt), 32'(vecs[i].g0));
      chk($sformatf("v%0d m1_gnt", i), 32'(m1_gnt), 32'(vecs[i].g1));
      chk($sformatf("v%0d m0_rvalid", i), 32'(m0_rvalid), 32'(vecs[i].v0));
      chk($sformatf("v%0d m1_rvalid", i), 32'(m1_rvalid), 32'(vecs[i].v1));
      if (vecs[i].v0) chk($sformatf("v%0d m0_rdata", i), m0_rdata, vecs[i].rd);
      if (vecs[i].v1) chk($sformatf("v%0d m1_rdata", i), m1_rdata, vecs[i].rd);
      chk($sformatf("v%0d read_en", i), 32'(mem_read_en), 32'(vecs[i].re));
      chk($sformatf("v%0d write_en", i), 32'(mem_write_en), 32'(vecs[i].we));
      chk($sformatf("v%0d read_addr", i), mem_read_addr, vecs[i].ra);
      chk($sformatf("v%0d write_addr", i), mem_write_addr, vecs[i].wa);
      chk($sformatf("v%0d write_data", i), mem_write_data, vecs[i].wd);
    end

    // Starvation bound: with both held, port 1 wins on cycles 9 and 18
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0;
      m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h4;
      #2;
      chk($sformatf("starve%0d m0_gnt", c), 32'(m0_gnt), 32'(!(c == 9 || c == 18)));
      chk($sformatf("starve%0d m1_gnt", c), 32'(m1_gnt), 32'(c == 9 || c == 18));
      chk($sformatf("starve%0d read_addr", c), mem_read_addr,
          (c == 9 || c == 18) ? 32'h4 : 32'h0);
    end
`endif

    // Asynchronous reset right after an m0 read grant
    @(negedge clk);
    idle();
    @(negedge clk);
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10;
    #2 chk("pre-rst m0_gnt", 32'(m0_gnt), 32'h1);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("async m0_gnt", 32'(m0_gnt), 32'h0);
    chk("async read_en", 32'(mem_read_en), 32'h0);
    chk("async read_addr", mem_read_addr, 32'h0);
    chk("async m0_rvalid", 32'(m0_rvalid), 32'h0);
    @(negedge clk);
    idle();
    @(negedge clk);
    rst = 1'b0;
    #2 chk("post-rst m0_rvalid a", 32'(m0_rvalid), 32'h0);
    @(negedge clk);
    #2 chk("post-rst m0_rvalid b", 32'(m0_rvalid), 32'h0);
    chk("post-rst m1_rvalid", 32'(m1_rvalid), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-requester arbiter that shares the single-read/single-write-port simulation data memory between port 0 (CPU load/store unit) and port 1 (debug/DMA loader).
- Each cycle, at most one requester is granted and its access is driven onto the memory's read or write interface.
- Read data (1-cycle registered latency in memory) is steered back to the requester that issued the read, qualified by a per-port rvalid pulse.
- Fixed priority with a starvation bound by default; round-robin optional.

Parameters:
W, `WORD_WIDTH (32), data/address width
MAX_WAIT, 8, max consecutive cycles port 1 may be refused under fixed priority before a forced grant (>=1)

Ports:
clk  in  1  clock, posedge
rst  in  1  asynchronous reset, active-high
m0_req  in  1  port 0 access request
m0_we  in  1  1 = write, 0 = read
m0_addr  in  W  byte address, passed through unmodified
m0_wdata  in  W  write data
m0_gnt  out  1  access accepted this cycle
m0_rvalid  out  1  read data valid for port 0
m0_rdata  out  W  read data for port 0
m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata  same as port 0, for port 1
mem_read_en  out  1  to memory read_en
mem_read_addr  out  W  to memory read_addr
mem_read_data  in  W  from memory read_data (registered, 1 cycle after read_en)
mem_write_en  out  1  to memory write_en
mem_write_addr  out  W  to memory write_addr
mem_write_data  out  W  to memory write_data

Behaviour:
- Reset (async, immediate):
  - clears pending-read register, last-grant pointer and wait counter.
  - while rst=1: all gnt, rvalid, mem_read_en and mem_write_en are 0; mem addr/data outputs are 0.
- Grant selection is combinational and takes effect in the same cycle. A requester holds req and its operands until it sees gnt; gnt is a one-cycle acceptance per access.
- Winner drives memory:
  - we=1: mem_write_en=1, write addr/data = winner's addr/wdata, mem_read_en=0.
  - we=0: mem_read_en=1, mem_read_addr = winner's addr, mem_write_en=0.
  - No winner: both enables 0, addr/data outputs 0.
- Read and write enables are never asserted in the same cycle.
- Read return: a 2-bit pending register {valid, port} is loaded at the posedge of a read grant.
  - Next cycle, mN_rvalid=1 for the recorded port only. Both mN_rdata = mem_read_data, meaningful only under rvalid.
  - Writes produce no rvalid.
  - Back-to-back reads (any port mix) are fully pipelined, one per cycle.
- Fixed priority (default):
  - m0 wins on contention.
  - wait_cnt, width $clog2(MAX_WAIT+1), increments each cycle m1_req=1 and m1_gnt=0.
  - It clears when m1 is granted or m1_req=0.
  - When wait_cnt==MAX_WAIT, m1 wins that cycle regardless of m0; m0 is refused and retries.
  - Counter saturates and never wraps.
- A single requester alone is granted every cycle.
- Reset mid-operation: a read granted in the cycle before reset produces no rvalid after reset deasserts.
- Memory forwarding is not duplicated here. A write then a read to the same address on consecutive cycles returns the new data, since the memory commits the write at the first edge.

Optional Feature:
Macro DMEM_ARB_RR_EN.
- Defined: round-robin arbitration.
  - A 1-bit last-grant pointer updates on every grant.
  - On contention, the port not granted last wins.
  - wait_cnt is not implemented; the starvation bound is 1 cycle.
- Undefined: fixed priority with the MAX_WAIT starvation counter as above; no last-grant pointer.

Test Plan:
- mem[0x10>>2]=0xDEADBEEF; m0 read 0x10 alone -> m0_gnt=1 that cycle; next cycle m0_rvalid=1, m0_rdata=0xDEADBEEF, m1_rvalid=0.
- m0 and m1 both write in the same cycle (fixed priority) -> m0_gnt=1, m1_gnt=0, mem_write_addr=m0_addr; m1 granted the following cycle once m0_req drops.
- Fixed priority, MAX_WAIT=8, m0_req and m1_req held high -> m1 refused 8 cycles, m1_gnt=1 on the 9th, m0_gnt=0 that cycle, counter back to 0.
- With DMEM_ARB_RR_EN, both ports issue continuous reads to 0x0 and 0x4 -> gnt alternates m0,m1,m0,...; rvalid alternates one cycle later with the matching words.
- m1 writes 0x12345678 to 0x20, then m0 reads 0x20 next cycle -> m0_rdata=0x12345678 with m0_rvalid.
- Assert rst asynchronously mid-cycle right after an m0 read grant -> gnt and enables drop immediately; m0_rvalid stays 0 through and after reset.
